uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-003 SHALL have parameter OVS, default 16, tick strobes per bit period, legal 4..32.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries, power of two, 2..64.
REQ-005 SHALL have port clk_master  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tick  input  1  oversample strobe, one clk_master cycle wide, synchronous to clk_master.
REQ-008 SHALL have port tx_en  input  1  transmit enable.
REQ-009 SHALL have port data_i  input  DATA_BITS  write data.
REQ-010 SHALL have port data_we_i  input  1  write strobe, one entry per high cycle.
REQ-011 SHALL have port par_odd_i  input  1  parity sense, 1 = odd, 0 = even (present only with UART_TX_PARITY_EN).
REQ-012 SHALL have port tx_o  output  1  serial line, idle high.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse at end of each frame.
REQ-014 SHALL have port full_o  output  1  FIFO full.
REQ-015 SHALL have port empty_o  output  1  FIFO empty.
REQ-016 SHALL have port overflow_o  output  1  one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL buffer writes in a FIFO_DEPTH-entry FIFO; data_we_i while full drops the word, leaves FIFO unchanged, pulses overflow_o next cycle.
REQ-018 SHALL accept a write while full if a pop occurs in the same cycle (simultaneous push/pop keeps count).
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL leave IDLE to START on the first tick where tx_en=1 and FIFO not empty, popping the head word in that cycle.
REQ-021 SHALL drive tx_o low for OVS ticks in START, then each data bit LSB-first for OVS ticks in DATA.
REQ-022 SHALL count data bits modulo DATA_BITS; after the last bit go to PARITY (if compiled) else STOP.
REQ-023 SHALL drive tx_o high for STOP_BITS*OVS ticks in STOP, then pulse tx_done for exactly one clk_master cycle.
REQ-024 SHALL, at end of STOP, go directly to START if tx_en=1 and FIFO not empty (back-to-back frames, no idle gap), else IDLE.
REQ-025 SHALL finish an in-flight frame when tx_en drops; tx_en only gates frame start.
REQ-026 SHALL advance all bit timing only on tick cycles; clk_master cycles without tick hold state.
REQ-027 SHALL register tx_o (no combinational path from inputs to tx_o).
REQ-028 SHALL drive empty_o/full_o combinationally from the FIFO count in the same cycle.

Reset
REQ-029 SHALL on rst_i asynchronously force: state IDLE, tx_o=1, tx_done=0, overflow_o=0, FIFO pointers/count 0, empty_o=1, full_o=0.
REQ-030 SHALL abort any frame in progress on reset and discard FIFO contents; first frame after release starts from IDLE.

Configuration
REQ-031 SHALL compile the parity bit in only when macro UART_TX_PARITY_EN is defined: PARITY state drives XOR of data bits (inverted when par_odd_i=1) for OVS ticks.
REQ-032 SHALL, without UART_TX_PARITY_EN, omit PARITY state and port par_odd_i; DATA goes straight to STOP.

Structure
REQ-033 SHALL place FSM state encoding and the legal-range constants in shared package uart_pkg.
REQ-034 SHALL implement the buffer as sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-035 SHALL cover: default params, write 0xDA, tx_en=1 -> tx_o = 0,0,1,0,1,1,0,1,1,1 (start, LSB-first, stop), each 16 ticks; tx_done after 160 ticks.
REQ-036 SHALL cover: write 4 words while tx_en=0, fifth write -> full_o=1, overflow_o pulses once, fifth word never sent.
REQ-037 SHALL cover: 3 words queued, tx_en=1 -> three frames back-to-back, no idle ticks between stop and next start, three tx_done pulses.
REQ-038 SHALL cover: UART_TX_PARITY_EN, par_odd_i=1, data 0x2D -> parity bit 1 after bit 7; par_odd_i=0 -> 0.
REQ-039 SHALL cover: rst_i asserted mid DATA bit 3 -> tx_o=1, empty_o=1 same cycle, no tx_done.
REQ-040 SHALL cover: tx_en dropped mid-frame with 2 words queued -> current frame completes, next not started until tx_en=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and legal parameter ranges.
// The parity state is only present when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DataBitsMin  = 5;
    localparam int unsigned DataBitsMax  = 9;
    localparam int unsigned StopBitsMin  = 1;
    localparam int unsigned StopBitsMax  = 2;
    localparam int unsigned OvsMin       = 4;
    localparam int unsigned OvsMax       = 32;
    localparam int unsigned FifoDepthMin = 2;
    localparam int unsigned FifoDepthMax = 64;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } tx_state_e;

    function automatic bit cfg_legal(input int unsigned data_bits, input int unsigned stop_bits,
                                     input int unsigned ovs, input int unsigned depth);
        bit ok;
        ok = (data_bits >= DataBitsMin) && (data_bits <= DataBitsMax);
        ok = ok && (stop_bits >= StopBitsMin) && (stop_bits <= StopBitsMax);
        ok = ok && (ovs >= OvsMin) && (ovs <= OvsMax);
        ok = ok && (depth >= FifoDepthMin) && (depth <= FifoDepthMax);
        ok = ok && ((depth & (depth - 1)) == 0);
        return ok;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata_o presents the head entry whenever the FIFO is not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_master,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned CountW = AddrW + 1;

    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CountW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_master or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_master) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO: start bit, LSB-first data, optional parity, stop bits.
// Define UART_TX_PARITY_EN to add the parity bit and the par_odd_i port.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_master,
    input  logic                 rst_i,
    input  logic                 tick,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 data_we_i,
`ifdef UART_TX_PARITY_EN
    input  logic                 par_odd_i,
`endif
    output logic                 tx_o,
    output logic                 tx_done,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o
);

    localparam int unsigned StopTicks = STOP_BITS * OVS;
    localparam int unsigned CntW      = $clog2(StopTicks);
    localparam int unsigned BitW      = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d, cnt_last;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic                 start_ok, start_now, bit_end, last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_master(clk_master),
        .rst_i     (rst_i),
        .push_i    (data_we_i),
        .wdata_i   (data_i),
        .pop_i     (fifo_pop),
        .rdata_o   (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign tx_o       = tx_q;
    assign tx_done    = done_q;
    assign overflow_o = overflow_q;

    // The stop phase is the only one that lasts longer than a single bit period.
    assign cnt_last  = (state_q == StStop) ? CntW'(StopTicks - 1) : CntW'(OVS - 1);
    assign bit_end   = tick & (cnt_q == cnt_last);
    assign last_bit  = (bit_cnt_q == BitW'(DATA_BITS - 1));
    assign start_ok  = tx_en & ~fifo_empty;
    assign start_now = tick & start_ok &
                       ((state_q == StIdle) | ((state_q == StStop) & bit_end));
    assign fifo_pop  = start_now;

    // A dropped write is one the FIFO cannot take because it is full and not draining.
    assign overflow_d = data_we_i & fifo_full & ~fifo_pop;

    always_ff @(posedge clk_master) begin
        assert (cfg_legal(DATA_BITS, STOP_BITS, OVS, FIFO_DEPTH))
            else $fatal(1, "uart_tx_fifo: parameter set out of range");
    end

    // State register.
    always_ff @(posedge clk_master or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state and bit timing; nothing advances on cycles without a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_d   = StData;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (last_bit) begin
                            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d   = StParity;
`else
                            state_d   = StStop;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        state_d = StStop;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        state_d = start_ok ? StStart : StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered line value, shifter and end-of-frame pulse.
    always_comb begin
        tx_d    = tx_q;
        done_d  = 1'b0;
        shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    tx_d = 1'b1;
                end
                StStart: begin
                    if (bit_end) begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            tx_d = parity_q;
`else
                            tx_d = 1'b1;
`endif
                        end else begin
                            tx_d    = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx_d = 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        tx_d   = 1'b1;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    tx_d = 1'b1;
                end
            endcase
        end
        // Loading a new word overrides the idle/stop level with the start bit.
        if (start_now) begin
            tx_d    = 1'b0;
            shreg_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = (^fifo_rdata) ^ par_odd_i;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo: the line is sampled on every tick and
// decoded against a frame model built from the data words. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned OVS        = 16;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif
    localparam int unsigned NBits      = 1 + DATA_BITS + ParBits + STOP_BITS;
    localparam int unsigned FrameTicks = NBits * OVS;
    localparam int          Budget     = 8000;

    logic                 clk_master = 1'b0;
    logic                 rst_i;
    logic                 tick;
    logic                 tx_en;
    logic [DATA_BITS-1:0] data_i;
    logic                 data_we_i;
    logic                 par_odd_i;
    logic                 tx_o, tx_done, full_o, empty_o, overflow_o;

    int   checks = 0;
    int   errors = 0;
    logic samples[$];
    int   done_at[$];
    int   ovf_cnt  = 0;
    int   scan_pos = 0;
    bit   tick_run = 1'b0;
    logic mon_tick;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .OVS       (OVS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_master(clk_master),
        .rst_i     (rst_i),
        .tick      (tick),
        .tx_en     (tx_en),
        .data_i    (data_i),
        .data_we_i (data_we_i),
`ifdef UART_TX_PARITY_EN
        .par_odd_i (par_odd_i),
`endif
        .tx_o      (tx_o),
        .tx_done   (tx_done),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_master = ~clk_master;

    // Irregular tick strobes: roughly one clock in three.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk_master);
            tick = tick_run && ($urandom_range(0, 2) == 0);
        end
    end

    // Line sample after every tick edge; tx_done is tagged with the tick index it follows.
    always @(posedge clk_master) begin
        mon_tick = tick;
        #1;
        if (mon_tick) samples.push_back(tx_o);
        if (tx_done) done_at.push_back(samples.size() - 1);
        if (overflow_o) ovf_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame bit k: 0 = start, then data LSB-first, then parity, then stop bits.
    function automatic bit exp_bit(input logic [DATA_BITS-1:0] d, input bit odd, input int k);
        if (k == 0) return 1'b0;
        if (k <= int'(DATA_BITS)) return d[k-1];
        if (ParBits == 1 && k == int'(DATA_BITS) + 1)
            return bit'(($countones(d) % 2) != 0) ^ odd;
        return 1'b1;
    endfunction

    function automatic int zeros_from(input int from);
        int n = 0;
        for (int i = from; i < samples.size(); i++) if (samples[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic push_word(input logic [DATA_BITS-1:0] d);
        @(negedge clk_master);
        data_i    = d;
        data_we_i = 1'b1;
        @(negedge clk_master);
        data_we_i = 1'b0;
    endtask

    task automatic wait_samples(input int n);
        int budget = Budget;
        while (samples.size() < n && budget > 0) begin
            @(negedge clk_master);
            budget--;
        end
        if (samples.size() < n) check_val("tick_wait_timeout", 0, 1);
    endtask

    task automatic find_start(output int st, output bit ok);
        int budget = Budget;
        ok = 1'b0;
        st = 0;
        while (!ok && budget > 0) begin
            while (!ok && scan_pos < samples.size()) begin
                if (samples[scan_pos] == 1'b0) begin
                    ok = 1'b1;
                    st = scan_pos;
                end else begin
                    scan_pos++;
                end
            end
            if (!ok) begin
                @(negedge clk_master);
                budget--;
            end
        end
        if (!ok) check_val("start_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input int st, input logic [DATA_BITS-1:0] d);
        int ones;
        int ndone;
        wait_samples(st + FrameTicks + 1);
        if (samples.size() <= st + FrameTicks) return;
        @(negedge clk_master);
        for (int b = 0; b < int'(NBits); b++) begin
            ones = 0;
            for (int i = 0; i < int'(OVS); i++) ones += int'(samples[st + b * OVS + i]);
            check_val($sformatf("%s_bit%0d", tag, b), ones,
                      exp_bit(d, par_odd_i, b) ? OVS : 0);
        end
        ndone = 0;
        foreach (done_at[i]) if (done_at[i] == st + int'(FrameTicks)) ndone++;
        check_val({tag, "_done_pulse"}, ndone, 1);
        scan_pos = st + FrameTicks;
    endtask

    task automatic expect_frame(input string tag, input logic [DATA_BITS-1:0] d, output int st);
        bit ok;
        find_start(st, ok);
        if (ok) check_frame(tag, st, d);
    endtask

    initial begin
        logic [DATA_BITS-1:0] w[$];
        logic [DATA_BITS-1:0] d;
        int st, prev_st, d0, ovf0, n;
        bit ok;

        rst_i = 1'b1; tx_en = 1'b0; data_we_i = 1'b0; data_i = '0; par_odd_i = 1'b0;
        repeat (3) @(negedge clk_master);
        check_val("rst_tx", tx_o, 1);
        check_val("rst_done", tx_done, 0);
        check_val("rst_ovf", overflow_o, 0);
        check_val("rst_empty", empty_o, 1);
        check_val("rst_full", full_o, 0);
        rst_i = 1'b0;
        tick_run = 1'b1;
        repeat (2) @(negedge clk_master);

        // Single frame, 0xDA.
        d = 8'hDA;
        push_word(d);
        check_val("da_empty_before", empty_o, 0);
        tx_en = 1'b1;
        expect_frame("da", d, st);
        check_val("da_empty_after", empty_o, 1);
        tx_en = 1'b0;

        // Fill the FIFO, then one write too many.
        w.delete();
        ovf0 = ovf_cnt;
        d0 = done_at.size();
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            d = DATA_BITS'($urandom);
            w.push_back(d);
            push_word(d);
        end
        check_val("fill_full", full_o, 1);
        check_val("fill_empty", empty_o, 0);
        push_word(~w[0]);
        check_val("ovf_pulse", overflow_o, 1);
        @(negedge clk_master);
        check_val("ovf_clear", overflow_o, 0);
        check_val("ovf_full_kept", full_o, 1);
        check_val("ovf_count", ovf_cnt - ovf0, 1);
        tx_en = 1'b1;
        foreach (w[i]) expect_frame($sformatf("fill%0d", i), w[i], st);
        wait_samples(samples.size() + 3 * OVS);
        check_val("fill_no_extra", zeros_from(scan_pos), 0);
        check_val("fill_done_count", done_at.size() - d0, FIFO_DEPTH);
        check_val("fill_empty_end", empty_o, 1);
        tx_en = 1'b0;

        // Three queued words go out back-to-back.
        w.delete();
        d0 = done_at.size();
        for (int i = 0; i < 3; i++) begin
            d = DATA_BITS'($urandom);
            w.push_back(d);
            push_word(d);
        end
        tx_en = 1'b1;
        prev_st = -1;
        foreach (w[i]) begin
            expect_frame($sformatf("b2b%0d", i), w[i], st);
            if (prev_st >= 0) check_val($sformatf("b2b_gap%0d", i), st - prev_st, FrameTicks);
            prev_st = st;
        end
        check_val("b2b_done_count", done_at.size() - d0, 3);
        tx_en = 1'b0;

        // tx_en dropped mid-frame with two words still queued.
        w.delete();
        for (int i = 0; i < 3; i++) begin
            d = DATA_BITS'($urandom);
            w.push_back(d);
            push_word(d);
        end
        tx_en = 1'b1;
        find_start(st, ok);
        tx_en = 1'b0;
        if (ok) check_frame("drop0", st, w[0]);
        d0 = done_at.size();
        wait_samples(samples.size() + 3 * OVS);
        check_val("drop_hold_line", zeros_from(scan_pos), 0);
        check_val("drop_hold_done", done_at.size() - d0, 0);
        check_val("drop_hold_empty", empty_o, 0);
        tx_en = 1'b1;
        expect_frame("drop1", w[1], st);
        expect_frame("drop2", w[2], st);
        tx_en = 1'b0;

        // Reset in the middle of data bit 3.
        d = DATA_BITS'($urandom);
        push_word(d);
        push_word(~d);
        tx_en = 1'b1;
        find_start(st, ok);
        wait_samples(st + 4 * OVS + OVS / 2);
        rst_i = 1'b1;
        #1;
        check_val("mid_rst_tx", tx_o, 1);
        check_val("mid_rst_empty", empty_o, 1);
        check_val("mid_rst_done", tx_done, 0);
        tx_en = 1'b0;
        repeat (3) @(negedge clk_master);
        rst_i = 1'b0;
        d0 = done_at.size();
        scan_pos = samples.size();
        wait_samples(samples.size() + 2 * OVS);
        check_val("post_rst_line", zeros_from(scan_pos), 0);
        check_val("post_rst_done", done_at.size() - d0, 0);
        d = DATA_BITS'($urandom);
        push_word(d);
        tx_en = 1'b1;
        expect_frame("post_rst", d, st);
        tx_en = 1'b0;

        // Randomized rounds: writes may land while a frame is already going out.
        ovf0 = ovf_cnt;
        for (int r = 0; r < 5; r++) begin
            w.delete();
            n = $urandom_range(1, FIFO_DEPTH);
            tx_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 20)) @(negedge clk_master);
                d = DATA_BITS'($urandom);
                w.push_back(d);
                push_word(d);
            end
            tx_en = 1'b1;
            foreach (w[i]) expect_frame($sformatf("rnd%0d_%0d", r, i), w[i], st);
            check_val($sformatf("rnd%0d_empty", r), empty_o, 1);
            tx_en = 1'b0;
        end
        check_val("rnd_no_ovf", ovf_cnt - ovf0, 0);

`ifdef UART_TX_PARITY_EN
        // Parity sense on 0x2D (four ones).
        for (int p = 1; p >= 0; p--) begin
            par_odd_i = 1'(p);
            d = 8'h2D;
            push_word(d);
            tx_en = 1'b1;
            find_start(st, ok);
            tx_en = 1'b0;
            if (ok) begin
                check_frame($sformatf("par%0d", p), st, d);
                check_val($sformatf("par%0d_bit", p), samples[st + (DATA_BITS + 1) * OVS + OVS / 2],
                          p);
            end
        end
        par_odd_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
